// File: rtl/ttt_pkg.sv
// Shared encodings, scan tables and FSM states for the tic-tac-toe auto player.
package ttt_pkg;

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] P1    = 2'b01;
  localparam logic [1:0] P2    = 2'b10;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_P1   = 2'b01;
  localparam logic [1:0] GS_P2   = 2'b10;
  localparam logic [1:0] GS_DONE = 2'b11;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int unsigned CNT_W = 5;

  localparam logic [3:0] LINE_TBL [0:7][0:2] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  localparam logic [3:0] PREF_TBL [0:8] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN_WIN,
    ST_SCAN_BLOCK,
    ST_PICK,
    ST_WAIT,
    ST_HOLD
  } state_e;

  function automatic logic [1:0] cell_of(input logic [17:0] brd, input logic [3:0] idx);
    logic [1:0] c;
    c = EMPTY;
    for (int unsigned i = 0; i < 9; i++) begin
      if (idx == 4'(i)) c = brd[2*i +: 2];
    end
    return c;
  endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Checks one three-cell line for two marks plus one empty cell; reports the empty slot.
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] c0_i,
  input  logic [1:0] c1_i,
  input  logic [1:0] c2_i,
  input  logic [1:0] mark_i,
  output logic       hit_o,
  output logic [1:0] pos_o
);

  always_comb begin
    hit_o = 1'b0;
    pos_o = 2'd0;
    if (c0_i == mark_i && c1_i == mark_i && c2_i == EMPTY) begin
      hit_o = 1'b1;
      pos_o = 2'd2;
    end else if (c0_i == mark_i && c2_i == mark_i && c1_i == EMPTY) begin
      hit_o = 1'b1;
      pos_o = 2'd1;
    end else if (c1_i == mark_i && c2_i == mark_i && c0_i == EMPTY) begin
      hit_o = 1'b1;
      pos_o = 2'd0;
    end
  end

endmodule

// File: rtl/ttt_auto_player.sv
// Hardware opponent: snapshots the board on its turn, scans win/block/preference
// one step per cycle, then issues a single-cycle move strobe.
module ttt_auto_player
  import ttt_pkg::*;
#(
  parameter logic [1:0]  OWN     = P2,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        enable,
  input  logic [17:0] gBoard,
  input  logic [1:0]  gameState,
  input  logic [1:0]  winner,
  output logic [3:0]  playerInput,
  output logic        playerWrite,
  output logic        busy,
  output logic        error
);

  localparam logic [1:0] OPP = ~OWN;

  state_e             state_q, state_d;
  logic [17:0]        brd_q, brd_d;
  logic [2:0]         line_q, line_d;
  logic [3:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [3:0]         pin_q, pin_d;
  logic               pw_q, pw_d;
  logic               err_q, err_d;

  logic               turn_ok;
  logic [1:0]         mark, pos;
  logic               hit;
  logic [3:0]         hit_cell, pick_cell;

  assign turn_ok = enable && (gameState == OWN) && (winner == WIN_NONE);
  assign mark    = (state_q == ST_SCAN_BLOCK) ? OPP : OWN;

  ttt_line_eval u_line_eval (
    .c0_i   (cell_of(brd_q, LINE_TBL[line_q][0])),
    .c1_i   (cell_of(brd_q, LINE_TBL[line_q][1])),
    .c2_i   (cell_of(brd_q, LINE_TBL[line_q][2])),
    .mark_i (mark),
    .hit_o  (hit),
    .pos_o  (pos)
  );

  always_comb begin
    case (pos)
      2'd0:    hit_cell = LINE_TBL[line_q][0];
      2'd1:    hit_cell = LINE_TBL[line_q][1];
      default: hit_cell = LINE_TBL[line_q][2];
    endcase
  end

  assign pick_cell = PREF_TBL[idx_q];
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    brd_d   = brd_q;
    line_d  = line_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pin_d   = pin_q;
    pw_d    = 1'b0;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (turn_ok) begin
          brd_d   = gBoard;
          line_d  = '0;
          state_d = ST_SCAN_WIN;
        end
      end
      ST_SCAN_WIN, ST_SCAN_BLOCK: begin
        // Abort is checked first so a hit on the same edge never writes.
        if (!turn_ok) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          pin_d   = hit_cell;
          pw_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (line_q == 3'd7) begin
          line_d  = '0;
          idx_d   = '0;
          state_d = (state_q == ST_SCAN_WIN) ? ST_SCAN_BLOCK : ST_PICK;
        end else begin
          line_d  = line_q + 3'd1;
        end
      end
      ST_PICK: begin
        if (!turn_ok) begin
          state_d = ST_IDLE;
        end else if (cell_of(brd_q, pick_cell) == EMPTY) begin
          pin_d   = pick_cell;
          pw_d    = 1'b1;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end else if (idx_q == 4'd8) begin
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          idx_d   = idx_q + 4'd1;
        end
      end
      ST_WAIT: begin
        // Losing the turn takes priority over a coincident timeout.
        if (!enable || gameState != OWN) begin
          state_d = ST_IDLE;
        end else if (32'(cnt_inc) >= TIMEOUT) begin
          cnt_d   = cnt_inc;
          err_d   = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_HOLD: begin
        if (!enable || gameState != OWN) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      brd_q   <= '0;
      line_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pin_q   <= '0;
      pw_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      brd_q   <= brd_d;
      line_q  <= line_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pin_q   <= pin_d;
      pw_q    <= pw_d;
      err_q   <= err_d;
    end
  end

  assign playerInput = pin_q;
  assign playerWrite = pw_q;
  assign busy        = (state_q != ST_IDLE);
  assign error       = err_q;

endmodule

// File: tb/tb_ttt_auto_player.sv
// Directed bench for ttt_auto_player playing as player 2.
module tb_ttt_auto_player;
  import ttt_pkg::*;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        enable;
  logic [17:0] gBoard;
  logic [1:0]  gameState;
  logic [1:0]  winner;
  logic [3:0]  playerInput;
  logic        playerWrite;
  logic        busy;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;

  ttt_auto_player #(.OWN(2'b10), .TIMEOUT(16)) dut (
    .ph1         (ph1),
    .reset       (reset),
    .enable      (enable),
    .gBoard      (gBoard),
    .gameState   (gameState),
    .winner      (winner),
    .playerInput (playerInput),
    .playerWrite (playerWrite),
    .busy        (busy),
    .error       (error)
  );

  always #5 ph1 = ~ph1;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Runs one turn: we = edge index of first write (-1 none), err_e = first edge error seen.
  task automatic run_turn(input logic [17:0] b, input int n_edges, input int drop_at,
                          input bit release_after, output int we, output int pin,
                          output int pw_n, output int err_e);
    @(negedge ph1);
    gBoard = b; gameState = GS_P2; winner = WIN_NONE;
    we = -1; pin = 0; pw_n = 0; err_e = -1;
    for (int e = 0; e < n_edges; e++) begin
      @(posedge ph1); #1;
      if (playerWrite) begin
        if (we < 0) begin we = e; pin = int'(playerInput); end
        pw_n++;
      end
      if (error && err_e < 0) err_e = e;
      if (e == drop_at || (release_after && we >= 0 && e > we)) gameState = GS_P1;
    end
  endtask

  task automatic idle_gap();
    @(negedge ph1);
    gameState = GS_IDLE; gBoard = '0;
    repeat (3) @(negedge ph1);
  endtask

  task automatic dir_turn(input string tag, input logic [17:0] b, input int exp_e, input int exp_pin);
    int we, pin, pw_n, err_e;
    run_turn(b, 30, -1, 1'b1, we, pin, pw_n, err_e);
    check_eq({tag, "_edge"}, we, exp_e);
    check_eq({tag, "_cell"}, pin, exp_pin);
    check_eq({tag, "_width"}, pw_n, 1);
    check_eq({tag, "_busy"}, int'(busy), 0);
    idle_gap();
  endtask

  initial begin
    int we, pin, pw_n, err_e;
    reset = 1'b1; enable = 1'b1; gBoard = '0; gameState = GS_IDLE; winner = WIN_NONE;
    #12;
    check_eq("rst_pin", int'(playerInput), 0);
    check_eq("rst_pw", int'(playerWrite), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_err", int'(error), 0);
    @(negedge ph1); reset = 1'b0;
    repeat (2) @(negedge ph1);

    dir_turn("win_l0", 18'h0014A, 1, 2);
    dir_turn("win_l7", 18'h02020, 8, 4);
    dir_turn("win_over_block", 18'h0A005, 3, 8);
    dir_turn("block_l0", 18'h00205, 9, 2);
    dir_turn("pref_empty", 18'h00000, 17, 4);
    dir_turn("pref_p1", 18'h00100, 18, 0);
    dir_turn("inv_no_hit", 18'h0000F, 17, 4);
    dir_turn("inv_center", 18'h00300, 18, 0);

    // Abort: turn lost at E5
    run_turn(18'h0, 30, 4, 1'b0, we, pin, pw_n, err_e);
    check_eq("abort_nowrite", pw_n, 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_err", err_e, -1);
    idle_gap();

    // Disabled: never plays
    enable = 1'b0;
    run_turn(18'h0, 30, -1, 1'b0, we, pin, pw_n, err_e);
    check_eq("dis_nowrite", pw_n, 0);
    check_eq("dis_busy", int'(busy), 0);
    enable = 1'b1;
    idle_gap();

    // Timeout: write at E17, error at E33, stays in HOLD
    run_turn(18'h0, 46, -1, 1'b0, we, pin, pw_n, err_e);
    check_eq("to_write_edge", we, 17);
    check_eq("to_err_edge", err_e, 33);
    check_eq("to_single_write", pw_n, 1);
    check_eq("to_hold_busy", int'(busy), 1);
    gameState = GS_P1;
    @(posedge ph1); #1;
    check_eq("to_idle_busy", int'(busy), 0);
    check_eq("to_err_sticky", int'(error), 1);
    idle_gap();

    // Reset mid-WAIT clears everything without a clock edge
    run_turn(18'h0, 20, -1, 1'b0, we, pin, pw_n, err_e);
    check_eq("rw_write_edge", we, 17);
    check_eq("rw_busy_pre", int'(busy), 1);
    check_eq("rw_pin_pre", int'(playerInput), 4);
    reset = 1'b1;
    #1;
    check_eq("rw_pin", int'(playerInput), 0);
    check_eq("rw_pw", int'(playerWrite), 0);
    check_eq("rw_busy", int'(busy), 0);
    check_eq("rw_err", int'(error), 0);
    @(negedge ph1); reset = 1'b0;
    idle_gap();

    // Full board: error at E25, no write
    run_turn(18'h15555, 30, -1, 1'b0, we, pin, pw_n, err_e);
    check_eq("full_nowrite", pw_n, 0);
    check_eq("full_err_edge", err_e, 25);
    check_eq("full_busy", int'(busy), 1);
    gameState = GS_P1;
    @(posedge ph1); #1;
    check_eq("full_idle", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
